// File: rtl/dcache_axi_pkg.sv
// Shared types and constants for the dcache AXI3 write-port arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// Provides the FSM state enum, AXI constants, default IDs and the counter update helper.
package dcache_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2
    } wr_state_e;

    localparam logic [2:0] AWSIZE_4B  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] DEF_M0_ID  = 4'd0;
    localparam logic [3:0] DEF_M1_ID  = 4'd1;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
    } aw_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_beat_t;

    // Outstanding counter step: saturates at both ends; inc and dec together cancel.
    function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
        logic [3:0] res;
        res = cnt;
        if (inc && !dec && (cnt != 4'hF)) res = cnt + 4'd1;
        if (dec && !inc && (cnt != 4'h0)) res = cnt - 4'd1;
        return res;
    endfunction

endpackage

// File: rtl/dcache_axi_wr_arbiter_rr.sv
// Two-requester round-robin pick: on contention the master not granted last time wins.
// Latency: combinational. Backpressure: none (pure function of the requests).
module rr_arbiter_2 (
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    output logic gnt_vld,
    output logic gnt_sel
);

    assign gnt_vld = req0 | req1;
    assign gnt_sel = (req0 && req1) ? ~rr_last : req1;

endmodule

// File: rtl/dcache_axi_wr_arbiter.sv
// Shares one AXI3 write port between the write-buffer drain (M0) and uncached stores (M1); optional DCACHE_WARB_FENCE_EN orders them.
// Latency: 1 cycle request-to-AW; W and B pass through combinationally while granted.
// Backpressure: awready/wready forwarded to the granted master only; a master at MAX_OUTST un-responded bursts is not granted.
module dcache_axi_wr_arbiter
    import dcache_axi_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 4,
    parameter logic [3:0]  M0_ID     = DEF_M0_ID,
    parameter logic [3:0]  M1_ID     = DEF_M1_ID
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic [31:0] m0_awaddr,
    input  logic [3:0]  m0_awlen,
    input  logic [1:0]  m0_awburst,
    input  logic        m0_awvalid,
    output logic        m0_awready,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_wlast,
    input  logic        m0_wvalid,
    output logic        m0_wready,
    output logic        m0_bvalid,

    input  logic [31:0] m1_awaddr,
    input  logic [3:0]  m1_awlen,
    input  logic [1:0]  m1_awburst,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wlast,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    output logic        m1_bvalid,

    output logic        outst_zero,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

    wr_state_e  state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_last_q, rr_last_d;
    logic [3:0] cnt0_q, cnt1_q;

    logic       elig0, elig1;
    logic       gnt_vld, gnt_sel;
    logic       aw_hs;
    logic       inc0, inc1, dec0, dec1;

    aw_req_t    m0_aw, m1_aw, aw_g;
    w_beat_t    m0_w, m1_w, w_g;
    logic       aw_g_vld, w_g_vld;
    logic [3:0] g_id;

    // Response status is not tracked; the cache treats every write as completed.
    logic       unused_bresp;
    assign unused_bresp = ^bresp;

`ifdef DCACHE_WARB_FENCE_EN
    // Strict ordering: a master may only start once the other has nothing outstanding.
    assign elig0 = m0_awvalid && (cnt0_q < MAX_CNT) && (cnt1_q == 4'd0);
    assign elig1 = m1_awvalid && (cnt1_q < MAX_CNT) && (cnt0_q == 4'd0);
`else
    assign elig0 = m0_awvalid && (cnt0_q < MAX_CNT);
    assign elig1 = m1_awvalid && (cnt1_q < MAX_CNT);
`endif

    rr_arbiter_2 u_rr (
        .req0    (elig0),
        .req1    (elig1),
        .rr_last (rr_last_q),
        .gnt_vld (gnt_vld),
        .gnt_sel (gnt_sel)
    );

    assign m0_aw    = '{addr: m0_awaddr, len: m0_awlen, burst: m0_awburst};
    assign m1_aw    = '{addr: m1_awaddr, len: m1_awlen, burst: m1_awburst};
    assign m0_w     = '{data: m0_wdata, strb: m0_wstrb, last: m0_wlast};
    assign m1_w     = '{data: m1_wdata, strb: m1_wstrb, last: m1_wlast};
    assign aw_g     = grant_q ? m1_aw : m0_aw;
    assign w_g      = grant_q ? m1_w  : m0_w;
    assign aw_g_vld = grant_q ? m1_awvalid : m0_awvalid;
    assign w_g_vld  = grant_q ? m1_wvalid  : m0_wvalid;
    assign g_id     = grant_q ? M1_ID : M0_ID;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        aw_hs      = 1'b0;
        awvalid    = 1'b0;
        awid       = 4'd0;
        awaddr     = 32'd0;
        awlen      = 4'd0;
        awburst    = 2'd0;
        wvalid     = 1'b0;
        wid        = 4'd0;
        wdata      = 32'd0;
        wstrb      = 4'd0;
        wlast      = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    grant_d = gnt_sel;
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                awvalid = aw_g_vld;
                awid    = g_id;
                awaddr  = aw_g.addr;
                awlen   = aw_g.len;
                awburst = aw_g.burst;
                if (grant_q) m1_awready = awready;
                else         m0_awready = awready;
                if (aw_g_vld && awready) begin
                    aw_hs     = 1'b1;
                    rr_last_d = grant_q;
                    state_d   = ST_W;
                end
            end
            ST_W: begin
                wvalid = w_g_vld;
                wid    = g_id;
                wdata  = w_g.data;
                wstrb  = w_g.strb;
                wlast  = w_g.last;
                if (grant_q) m1_wready = wready;
                else         m0_wready = wready;
                if (w_g_vld && wready && w_g.last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Responses are routed by BID alone; unknown IDs match neither master and vanish.
    assign dec0      = bvalid && (bid == M0_ID);
    assign dec1      = bvalid && (bid == M1_ID);
    assign inc0      = aw_hs && !grant_q;
    assign inc1      = aw_hs &&  grant_q;
    assign m0_bvalid = dec0;
    assign m1_bvalid = dec1;

    assign awsize     = AWSIZE_4B;
    assign bready     = 1'b1;
    assign outst_zero = (state_q == ST_IDLE) && (cnt0_q == 4'd0) && (cnt1_q == 4'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            cnt0_q    <= 4'd0;
            cnt1_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            cnt0_q    <= cnt_next(cnt0_q, inc0, dec0);
            cnt1_q    <= cnt_next(cnt1_q, inc1, dec1);
        end
    end

endmodule

// File: tb/tb_dcache_axi_wr_arbiter.sv
// Bench for dcache_axi_wr_arbiter: scoreboarded AW/W traffic, B routing table, and ordering corner cases.
module tb_dcache_axi_wr_arbiter;
    import dcache_axi_pkg::*;

    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rstn;
    logic [31:0] m0_awaddr, m1_awaddr, m0_wdata, m1_wdata;
    logic [3:0]  m0_awlen, m1_awlen, m0_wstrb, m1_wstrb;
    logic [1:0]  m0_awburst, m1_awburst;
    logic        m0_awvalid, m1_awvalid, m0_awready, m1_awready;
    logic        m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_wready, m1_wready;
    logic        m0_bvalid, m1_bvalid, outst_zero;
    logic [3:0]  awid, awlen, wid, wstrb, bid;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    dcache_axi_wr_arbiter #(.MAX_OUTST(MAXO), .M0_ID(4'd0), .M1_ID(4'd1)) dut (
        .clk(clk), .rstn(rstn),
        .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awburst(m0_awburst),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_bvalid(m0_bvalid),
        .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awburst(m1_awburst),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_bvalid(m1_bvalid),
        .outst_zero(outst_zero),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
    } aw_exp_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_exp_t;

    typedef struct {
        logic       bv;
        logic [3:0] id;
        logic       e0;
        logic       e1;
    } bvec_t;

    aw_exp_t exp_aw_q[$];
    w_exp_t  exp_w_q[$];
    aw_exp_t mon_a;
    w_exp_t  mon_w;
    bvec_t   btab[6];
    int      n_checks = 0;
    int      n_fail   = 0;
    logic    pair_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] addr, input int b);
        return addr ^ (32'hA5A5_0000 + 32'(b * 17));
    endfunction

    function automatic logic [3:0] beat_strb(input int b);
        logic [3:0] s;
        s = 4'hF >> (b & 3);
        return s;
    endfunction

    function automatic logic get_awready(input int m);
        return (m == 0) ? m0_awready : m1_awready;
    endfunction

    function automatic logic get_wready(input int m);
        return (m == 0) ? m0_wready : m1_wready;
    endfunction

    task automatic drive_aw(input int m, input logic v, input logic [31:0] addr, input logic [3:0] len);
        if (m == 0) begin
            m0_awvalid = v; m0_awaddr = addr; m0_awlen = len; m0_awburst = BURST_INCR;
        end else begin
            m1_awvalid = v; m1_awaddr = addr; m1_awlen = len; m1_awburst = BURST_INCR;
        end
    endtask

    task automatic drive_w(input int m, input logic v, input logic [31:0] d, input logic [3:0] s, input logic l);
        if (m == 0) begin
            m0_wvalid = v; m0_wdata = d; m0_wstrb = s; m0_wlast = l;
        end else begin
            m1_wvalid = v; m1_wdata = d; m1_wstrb = s; m1_wlast = l;
        end
    endtask

    task automatic expect_burst(input int m, input logic [31:0] addr, input logic [3:0] len);
        aw_exp_t a;
        w_exp_t  w;
        logic [3:0] id;
        id = (m == 0) ? 4'd0 : 4'd1;
        a  = '{id, addr, len, BURST_INCR};
        exp_aw_q.push_back(a);
        for (int b = 0; b <= int'(len); b++) begin
            w = '{id, beat_data(addr, b), beat_strb(b), (b == int'(len))};
            exp_w_q.push_back(w);
        end
    endtask

    // Master-side driver; gives up quietly if reset is asserted underneath it.
    task automatic burst(input int m, input logic [31:0] addr, input logic [3:0] len);
        int   guard;
        logic hs;
        drive_aw(m, 1'b1, addr, len);
        guard = 0; hs = 1'b0;
        while (!hs && guard < 300 && rstn) begin
            @(negedge clk); guard++; hs = get_awready(m);
        end
        if (!hs) begin
            if (rstn) check($sformatf("m%0d_aw_grant_timeout", m), hs, 1'b1);
            drive_aw(m, 1'b0, 32'd0, 4'd0);
            return;
        end
        @(posedge clk); #1;
        drive_aw(m, 1'b0, 32'd0, 4'd0);
        for (int b = 0; b <= int'(len); b++) begin
            drive_w(m, 1'b1, beat_data(addr, b), beat_strb(b), (b == int'(len)));
            guard = 0; hs = 1'b0;
            while (!hs && guard < 300 && rstn) begin
                @(negedge clk); guard++; hs = get_wready(m);
            end
            if (!hs) begin
                if (rstn) check($sformatf("m%0d_w_beat_timeout", m), hs, 1'b1);
                drive_w(m, 1'b0, 32'd0, 4'd0, 1'b0);
                return;
            end
            @(posedge clk); #1;
        end
        drive_w(m, 1'b0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic send_b(input logic [3:0] id);
        bvalid = 1'b1; bid = id;
        @(negedge clk);
        check($sformatf("b_route_m0_bid%0d", id), m0_bvalid, (id == 4'd0));
        check($sformatf("b_route_m1_bid%0d", id), m1_bvalid, (id == 4'd1));
        @(posedge clk); #1;
        bvalid = 1'b0; bid = 4'd0;
    endtask

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic run_pair(input int first, input logic [31:0] a0, input logic [31:0] a1, input logic bp);
        if (first == 0) begin
            expect_burst(0, a0, 4'd3); expect_burst(1, a1, 4'd1);
        end else begin
            expect_burst(1, a1, 4'd1); expect_burst(0, a0, 4'd3);
        end
        pair_done = 1'b0;
        fork
            begin
                fork
                    burst(0, a0, 4'd3);
                    burst(1, a1, 4'd1);
                join
                pair_done = 1'b1;
            end
            begin
                while (!pair_done && bp) begin
                    @(posedge clk); #1;
                    awready = 1'($urandom_range(0, 1));
                    wready  = 1'($urandom_range(0, 1));
                end
            end
        join
        awready = 1'b1; wready = 1'b1;
        send_b(4'd0); send_b(4'd1);
        @(negedge clk);
        check("pair_outst_zero", outst_zero, 1'b1);
        sync();
    endtask

    always @(negedge clk) begin
        if (rstn && awvalid && awready) begin
            if (exp_aw_q.size() == 0) check("aw_unexpected", 1'b1, 1'b0);
            else begin
                mon_a = exp_aw_q.pop_front();
                check("aw_fields", {awid, awaddr, awlen, awburst}, mon_a);
                check("awsize", awsize, AWSIZE_4B);
            end
        end
        if (rstn && wvalid && wready) begin
            if (exp_w_q.size() == 0) check("w_unexpected", 1'b1, 1'b0);
            else begin
                mon_w = exp_w_q.pop_front();
                check("w_beat", {wid, wdata, wstrb, wlast}, mon_w);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt, guard;
        logic hs;
        btab[0] = '{1'b1, 4'd0, 1'b1, 1'b0};
        btab[1] = '{1'b1, 4'd1, 1'b0, 1'b1};
        btab[2] = '{1'b1, 4'd5, 1'b0, 1'b0};
        btab[3] = '{1'b0, 4'd0, 1'b0, 1'b0};
        btab[4] = '{1'b0, 4'd1, 1'b0, 1'b0};
        btab[5] = '{1'b1, 4'd15, 1'b0, 1'b0};

        rstn = 1'b0;
        drive_aw(0, 1'b0, 32'd0, 4'd0); drive_aw(1, 1'b0, 32'd0, 4'd0);
        drive_w(0, 1'b0, 32'd0, 4'd0, 1'b0); drive_w(1, 1'b0, 32'd0, 4'd0, 1'b0);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bid = 4'd0; bresp = 2'd0;
        #12;
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_m_readys", {m0_awready, m1_awready, m0_wready, m1_wready}, 4'b0);
        check("rst_aw_fields", {awid, awaddr, awlen, awburst}, 42'd0);
        check("rst_bready", bready, 1'b1);
        check("rst_outst_zero", outst_zero, 1'b1);
        sync();
        rstn = 1'b1;
        sync();

        // B routing at zero outstanding: pulses follow BID, counters must not underflow
        foreach (btab[i]) begin
            bvalid = btab[i].bv; bid = btab[i].id;
            @(negedge clk);
            check($sformatf("btab%0d_m0_bvalid", i), m0_bvalid, btab[i].e0);
            check($sformatf("btab%0d_m1_bvalid", i), m1_bvalid, btab[i].e1);
            check($sformatf("btab%0d_outst_zero", i), outst_zero, 1'b1);
            sync();
        end
        bvalid = 1'b0; bid = 4'd0;

        // Simultaneous requests: M0 first after reset, and again after an M1 grant
        run_pair(0, 32'h2000_0000, 32'h2100_0004, 1'b1);
        run_pair(0, 32'h2000_0100, 32'h2100_0104, 1'b0);

        // M0 alone: one-cycle arbitration latency, 8-beat line
        expect_burst(0, 32'h1000_0020, 4'd7);
        fork
            burst(0, 32'h1000_0020, 4'd7);
            begin
                @(negedge clk); check("t1_aw_before_grant", awvalid, 1'b0);
                @(negedge clk); check("t1_aw_after_grant", {awvalid, m0_awready, m1_awready}, 3'b110);
            end
        join
        @(negedge clk); check("t1_outst_busy", outst_zero, 1'b0);
        sync(); send_b(4'd0);
        @(negedge clk); check("t1_outst_zero", outst_zero, 1'b1);
        sync();

        // After an M0-only grant, contention goes to M1 first
        run_pair(1, 32'h2000_0200, 32'h2100_0204, 1'b1);

        // Outstanding limit on M0
        expect_burst(0, 32'h3000_0000, 4'd1); burst(0, 32'h3000_0000, 4'd1);
        expect_burst(0, 32'h3000_0040, 4'd1); burst(0, 32'h3000_0040, 4'd1);
`ifdef DCACHE_WARB_FENCE_EN
        expect_burst(0, 32'h3000_0080, 4'd1); expect_burst(1, 32'h3100_0000, 4'd1);
`else
        expect_burst(1, 32'h3100_0000, 4'd1); expect_burst(0, 32'h3000_0080, 4'd1);
`endif
        fork
            burst(0, 32'h3000_0080, 4'd1);
            burst(1, 32'h3100_0000, 4'd1);
            begin
                repeat (20) @(negedge clk);
                check("t3_limit_holds_m0", awvalid, 1'b0);
                sync(); send_b(4'd0);
`ifdef DCACHE_WARB_FENCE_EN
                repeat (20) @(negedge clk);
                check("t3_fence_holds_m1", awvalid, 1'b0);
                sync(); send_b(4'd0); send_b(4'd0);
`endif
            end
        join
`ifdef DCACHE_WARB_FENCE_EN
        send_b(4'd1);
`else
        send_b(4'd0); send_b(4'd0); send_b(4'd1);
`endif
        @(negedge clk); check("t3_outst_zero", outst_zero, 1'b1);
        sync();

        // B for M0 in the same cycle as its AW handshake leaves the count unchanged
        expect_burst(0, 32'h4000_0000, 4'd1); burst(0, 32'h4000_0000, 4'd1);
        expect_burst(0, 32'h4000_0040, 4'd1);
        fork
            burst(0, 32'h4000_0040, 4'd1);
            begin
                guard = 0; hs = 1'b0;
                while (!hs && guard < 300) begin
                    @(negedge clk); guard++; hs = awvalid && m0_awready;
                end
                if (!hs) check("t4_aw_timeout", hs, 1'b1);
                else begin
                    bvalid = 1'b1; bid = 4'd0;
                    #1 check("t4_b_during_aw", m0_bvalid, 1'b1);
                    sync();
                    bvalid = 1'b0;
                end
            end
        join
        @(negedge clk); check("t4_cnt_still_one", outst_zero, 1'b0);
        sync(); send_b(4'd5);
        @(negedge clk); check("t4_unknown_bid_ignored", outst_zero, 1'b0);
        sync(); send_b(4'd0);
        @(negedge clk); check("t4_outst_zero", outst_zero, 1'b1);
        sync();

        // Asynchronous reset in the middle of a line burst
        expect_burst(0, 32'h5000_0000, 4'd7);
        fork
            burst(0, 32'h5000_0000, 4'd7);
            begin
                cnt = 0; guard = 0;
                while (cnt < 2 && guard < 300) begin
                    @(negedge clk); guard++;
                    if (wvalid && wready) cnt++;
                end
                @(posedge clk); #2;
                rstn = 1'b0;
                #1;
                check("t5_rst_valids", {awvalid, wvalid}, 2'b00);
                check("t5_rst_readys", {m0_awready, m0_wready, m1_awready, m1_wready}, 4'b0);
                check("t5_rst_outst_zero", outst_zero, 1'b1);
            end
        join
        exp_aw_q.delete(); exp_w_q.delete();
        repeat (2) sync();
        rstn = 1'b1;
        sync();
        expect_burst(1, 32'h5100_0008, 4'd1); burst(1, 32'h5100_0008, 4'd1);
        send_b(4'd1);
        @(negedge clk); check("t5_post_rst_outst_zero", outst_zero, 1'b1);
        sync();

        // M1 request while an M0 burst is outstanding
        expect_burst(0, 32'h6000_0000, 4'd7); burst(0, 32'h6000_0000, 4'd7);
        expect_burst(1, 32'h6100_0000, 4'd0);
        sync();
        fork
            burst(1, 32'h6100_0000, 4'd0);
            begin
`ifdef DCACHE_WARB_FENCE_EN
                repeat (5) @(negedge clk);
                check("t6_fence_holds", awvalid, 1'b0);
                sync(); send_b(4'd0);
`endif
                @(negedge clk); check("t6_aw_before_grant", awvalid, 1'b0);
                @(negedge clk); check("t6_aw_granted", {awvalid, m1_awready}, 2'b11);
            end
        join
`ifndef DCACHE_WARB_FENCE_EN
        send_b(4'd0);
`endif
        send_b(4'd1);
        @(negedge clk); check("t6_outst_zero", outst_zero, 1'b1);

        repeat (5) sync();
        check("aw_queue_drained", 32'(exp_aw_q.size()), 32'd0);
        check("w_queue_drained", 32'(exp_w_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
